// File: rtl/cordic_vectoring_clocked.sv
// Iterative vectoring-mode CORDIC: converts a Cartesian vector (x, y) into
// atan2(y, x) as a 32-bit binary angle plus its gain-compensated magnitude.
module cordic_vectoring_clocked #(
  parameter int ITERATIONS = 30,
  parameter int GUARD      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  output logic [31:0] angle_out,
  output logic [31:0] mag_out,
  output logic        busy,
  output logic        done
);

  localparam int          W         = 34 + GUARD;
  localparam int          WP1       = W + 1;
  localparam int          PW        = W + 32;
  localparam int          RSH       = (GUARD > 0) ? GUARD - 1 : 0;
  localparam logic [W:0]  MAG_ROUND = (GUARD > 0) ? (WP1'(1) << RSH) : '0;
  localparam logic [31:0] INV_K     = 32'h9B74EDA8;
  localparam logic [4:0]  LAST      = 5'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;

  state_t              state, state_next;
  logic signed [W-1:0] x, y;
  logic signed [W-1:0] x_load, y_load, x_shift, y_shift;
  logic signed [33:0]  x_ext, y_ext;
  logic [31:0]         z, z_load;
  logic [4:0]          count;
  logic                zero_vec;
  logic [PW-1:0]       prod;
  logic [W-1:0]        mag_q;
  logic [W:0]          mag_r;
  logic [31:0]         mag_sat;

  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h20000000;
      5'd1:  return 32'h12E4051E;
      5'd2:  return 32'h09FB385B;
      5'd3:  return 32'h051111D4;
      5'd4:  return 32'h028B0D43;
      5'd5:  return 32'h0145D7E1;
      5'd6:  return 32'h00A2F61E;
      5'd7:  return 32'h00517C55;
      5'd8:  return 32'h0028BE53;
      5'd9:  return 32'h00145F2F;
      5'd10: return 32'h000A2F98;
      5'd11: return 32'h000517CC;
      5'd12: return 32'h00028BE6;
      5'd13: return 32'h000145F3;
      5'd14: return 32'h0000A2FA;
      5'd15: return 32'h0000517D;
      5'd16: return 32'h000028BE;
      5'd17: return 32'h0000145F;
      5'd18: return 32'h00000A30;
      5'd19: return 32'h00000518;
      5'd20: return 32'h0000028C;
      5'd21: return 32'h00000146;
      5'd22: return 32'h000000A3;
      5'd23: return 32'h00000051;
      5'd24: return 32'h00000029;
      5'd25: return 32'h00000014;
      5'd26: return 32'h0000000A;
      5'd27: return 32'h00000005;
      5'd28: return 32'h00000003;
      5'd29: return 32'h00000001;
      5'd30: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  // Left-half-plane inputs are rotated by pi first so the iterations only
  // ever need to cover +/- pi/2; negation happens at 34 bits so -2^31 is exact.
  always_comb begin
    x_ext = {{2{x_in[31]}}, x_in};
    y_ext = {{2{y_in[31]}}, y_in};
    if (x_in[31]) begin
      x_load = W'(-x_ext) <<< GUARD;
      y_load = W'(-y_ext) <<< GUARD;
      z_load = 32'h80000000;
    end else begin
      x_load = W'(x_ext) <<< GUARD;
      y_load = W'(y_ext) <<< GUARD;
      z_load = 32'h00000000;
    end
    x_shift = x >>> count;
    y_shift = y >>> count;
    prod    = PW'($unsigned(x)) * PW'(INV_K) + (PW'(1) << 31);
    mag_q   = W'(prod >> 32);
    mag_r   = ({1'b0, mag_q} + MAG_ROUND) >> GUARD;
    mag_sat = (|mag_r[W:32]) ? 32'hFFFFFFFF : mag_r[31:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ITER;
      ITER:    if (count == LAST) state_next = SCALE;
      SCALE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The zero vector is flagged at load because the iterations would otherwise
  // accumulate the full atan table into z.
  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      z         <= '0;
      count     <= '0;
      zero_vec  <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x        <= x_load;
            y        <= y_load;
            z        <= z_load;
            count    <= '0;
            zero_vec <= (x_in == 32'd0) && (y_in == 32'd0);
            busy     <= 1'b1;
          end
        end
        ITER: begin
          if (!y[W-1]) begin
            x <= x + y_shift;
            y <= y - x_shift;
            z <= z + atan_lut(count);
          end else begin
            x <= x - y_shift;
            y <= y + x_shift;
            z <= z - atan_lut(count);
          end
          count <= count + 5'd1;
        end
        SCALE: begin
          angle_out <= zero_vec ? 32'd0 : z;
          mag_out   <= mag_sat;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_clocked.sv
// Randomised bench for cordic_vectoring_clocked: an ideal atan2/hypot model
// with cycle-exact handshake timing is compared against the DUT every cycle.
module tb_cordic_vectoring_clocked;

  localparam int  ITERATIONS = 30;
  localparam int  GUARD      = 8;
  localparam real PI         = 3.14159265358979323846;
  localparam int  ANGLE_TOL  = 64;
  localparam int  MAG_TOL    = 4;
  localparam int  RANDOM_OPS = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic [31:0] angle_out, mag_out;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  cordic_vectoring_clocked #(.ITERATIONS(ITERATIONS), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .angle_out(angle_out), .mag_out(mag_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } op_t;

  function automatic logic [31:0] idealAngle(input logic signed [31:0] xv, input logic signed [31:0] yv);
    real    a;
    longint r;
    a = $atan2(real'(yv), real'(xv)) * 2147483648.0 / PI;
    r = longint'($floor(a + 0.5));
    return r[31:0];
  endfunction

  function automatic longint idealMag(input logic signed [31:0] xv, input logic signed [31:0] yv);
    real m;
    m = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
    return longint'($floor(m + 0.5));
  endfunction

  function automatic bit angleClose(input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d;
    int          sd;
    d  = a - e;
    sd = int'(d);
    return (sd >= -ANGLE_TOL) && (sd <= ANGLE_TOL);
  endfunction

  function automatic bit magClose(input logic [31:0] m, input longint e);
    longint d;
    d = longint'(m) - e;
    return (d >= -MAG_TOL) && (d <= MAG_TOL);
  endfunction

  task automatic checkOutput(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, req);
    end
  endtask

  // Reference model: idle/busy/done timing from a countdown, values from ideal maths.
  op_t         pending[$];
  op_t         last_op;
  int          remaining   = 0;
  bit          model_valid = 1'b0;
  bit          exp_done    = 1'b0;
  bit          exp_exact   = 1'b1;
  logic [31:0] exp_angle   = '0;
  longint      exp_mag     = 0;

  always @(posedge clk) begin
    exp_done = 1'b0;
    if (rst) begin
      pending.delete();
      remaining   = 0;
      model_valid = 1'b1;
      exp_exact   = 1'b1;
      exp_angle   = '0;
      exp_mag     = 0;
    end else if (remaining == 0) begin
      if (start) begin
        pending.push_back('{x: x_in, y: y_in});
        remaining = ITERATIONS + 1;
      end
    end else begin
      remaining--;
      if (remaining == 0) begin
        exp_done = 1'b1;
        last_op  = pending.pop_front();
        if (last_op.x == 32'd0 && last_op.y == 32'd0) begin
          exp_exact = 1'b1;
          exp_angle = '0;
          exp_mag   = 0;
        end else begin
          exp_exact = 1'b0;
          exp_angle = idealAngle(last_op.x, last_op.y);
          exp_mag   = idealMag(last_op.x, last_op.y);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("done", done == exp_done, longint'(done), longint'(exp_done));
      checkOutput("busy", busy == (remaining != 0), longint'(busy), longint'(remaining != 0));
      checkOutput(exp_done ? "angle_done" : "angle_hold",
                  exp_exact ? (angle_out == exp_angle) : angleClose(angle_out, exp_angle),
                  longint'(angle_out), longint'(exp_angle));
      checkOutput(exp_done ? "mag_done" : "mag_hold",
                  exp_exact ? (longint'(mag_out) == exp_mag) : magClose(mag_out, exp_mag),
                  longint'(mag_out), exp_mag);
    end
  end

  // Called at a negedge while the DUT is idle or showing done; returns at the
  // negedge where done is seen, so consecutive calls exercise back-to-back starts.
  task automatic applyStimulus(input logic [31:0] xv, input logic [31:0] yv, input bit noisy);
    int waited;
    waited = 0;
    x_in   = xv;
    y_in   = yv;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && waited < 100) begin
      if (noisy) begin
        start = ($urandom_range(0, 3) == 0);
        x_in  = $urandom;
        y_in  = $urandom;
      end
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, want done within 100", waited);
    end
  endtask

  initial begin
    logic signed [31:0] rx, ry;
    int                 sh;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("model_diag_angle", idealAngle(32'h40000000, 32'h40000000) == 32'h20000000,
                longint'(idealAngle(32'h40000000, 32'h40000000)), 64'h20000000);
    checkOutput("model_diag_mag", idealMag(32'h40000000, 32'h40000000) == 64'h5A82799A,
                idealMag(32'h40000000, 32'h40000000), 64'h5A82799A);
    checkOutput("model_q3_angle", idealAngle(32'h80000000, 32'h80000000) == 32'hA0000000,
                longint'(idealAngle(32'h80000000, 32'h80000000)), 64'hA0000000);
    checkOutput("model_q3_mag", idealMag(32'h80000000, 32'h80000000) == 64'hB504F334,
                idealMag(32'h80000000, 32'h80000000), 64'hB504F334);
    checkOutput("model_negx_angle", idealAngle(32'hC0000000, 32'h0) == 32'h80000000,
                longint'(idealAngle(32'hC0000000, 32'h0)), 64'h80000000);

    applyStimulus(32'h40000000, 32'h00000000, 1'b0);
    applyStimulus(32'h00000000, 32'h40000000, 1'b0);
    applyStimulus(32'hC0000000, 32'h00000000, 1'b1);
    applyStimulus(32'h40000000, 32'h40000000, 1'b1);
    applyStimulus(32'h80000000, 32'h80000000, 1'b0);
    applyStimulus(32'h00000000, 32'h00000000, 1'b0);
    applyStimulus(32'h00000000, 32'hC0000000, 1'b1);
    applyStimulus(32'h80000000, 32'h00000000, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b0);

    x_in  = 32'h12345678;
    y_in  = 32'h23456789;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(32'hE0000000, 32'h30000000, 1'b0);

    for (int n = 0; n < RANDOM_OPS; n++) begin
      do begin
        rx = $urandom;
        ry = $urandom;
        sh = $urandom_range(0, 7);
        rx = rx >>> sh;
        ry = ry >>> sh;
      end while (idealMag(rx, ry) < 64'd16777216);
      applyStimulus(rx, ry, bit'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
